// File: rtl/apb_master.sv
// apb_master: single-outstanding load/store to APB initiator with store lane steering and load extension.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without pready.
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    input  logic                  pready,
    input  logic                  perr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nx;
    logic [1:0] size_q;
    logic uns_q, accept, legal, timeout;
    logic [3:0] mask;
    logic [DATA_WIDTH-1:0] ext;
    assign req_ready = (state == IDLE) && presetn;
    assign accept    = req_valid && req_ready;
    assign legal     = req_size != 2'b11;
    assign psel      = state != IDLE;
    assign penable   = state == ACCESS;
    assign mask      = req_size == 2'b00 ? 4'b0001 : req_size == 2'b01 ? 4'b0011 : 4'b1111;
    assign ext = size_q == 2'b00 ? {{24{!uns_q && prdata[7]}}, prdata[7:0]} :
                 size_q == 2'b01 ? {{16{!uns_q && prdata[15]}}, prdata[15:0]} : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // cnt is held at zero outside ACCESS, so it restarts on every entry
    assign timeout = (state == ACCESS) && !pready && (cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge pclk) begin
        if (!presetn || state != ACCESS) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout = 1'b0;
`endif
    always_ff @(posedge pclk) begin
        state <= presetn ? state_nx : IDLE;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept && legal ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = pready || timeout ? IDLE : ACCESS;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            paddr      <= '0;
            pdata      <= '0;
            pstb       <= 4'b0000;
            pwrite     <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            if (accept && legal) begin
                paddr  <= req_addr;
                pwrite <= req_write;
                pdata  <= req_write ? req_wdata << {req_addr[1:0], 3'b000} : '0;
                pstb   <= req_write ? 4'(mask << req_addr[1:0]) : 4'b0000;
                size_q <= req_size;
                uns_q  <= req_unsigned;
            end
            if ((accept && !legal) || timeout) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_rdata <= '0;
            end else if (state == ACCESS && pready) begin
                resp_valid <= 1'b1;
                resp_err   <= perr;
                resp_rdata <= perr || pwrite ? '0 : ext;
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: vector table plus scoreboard against a word-addressed responder model.
module tb_apb_master;
    localparam int TO = 16;
    logic pclk = 1'b0, presetn = 1'b0;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0] req_size = 2'b00;
    logic resp_valid, resp_err, psel, penable, pwrite, pready, perr;
    logic [31:0] resp_rdata, paddr, pdata, prdata;
    logic [3:0] pstb;
    logic [31:0] mem [64];
    logic preload = 1'b1, err_en = 1'b0;
    int wait_n = 1;
    logic [7:0] acc_cnt = '0;
    int cyc = 0, n_checks = 0, n_fail = 0;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .paddr(paddr), .pdata(pdata), .prdata(prdata), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pstb(pstb), .pready(pready), .perr(perr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Responder: pready after wait_n extra ACCESS cycles; read data right-shifted to lane 0
    always @(posedge pclk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 8'd1 : 8'd0;
    assign pready = psel && penable && (int'(acc_cnt) == wait_n);
    assign perr   = pready && err_en;
    assign prdata = mem[paddr[7:2]] >> {paddr[1:0], 3'b000};
    always @(posedge pclk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[4] <= 32'hDEADBEEF;
            mem[5] <= 32'h80017F00;
            mem[8] <= 32'hAABBCCDD;
        end else if (psel && penable && pready && pwrite && !perr) begin
            for (int i = 0; i < 4; i++)
                if (pstb[i]) mem[paddr[7:2]][8*i +: 8] <= pdata[8*i +: 8];
        end
    end

    typedef struct {
        logic [31:0] addr, wdata;
        logic write;
        logic [1:0] size;
        logic uns, err_inj;
        int wait_n;
        logic [31:0] exp_rdata;
        logic exp_err;
        logic [3:0] exp_pstb;
        logic [31:0] exp_pdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata, paddr, pdata;
        logic err, pwrite;
        logic [3:0] pstb;
        int lat, cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        int n = 0;
        int lat;
        @(negedge pclk);
        while (!req_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_wait: req_ready stuck at 0 after %0d cycles", n);
            return;
        end
        lat = v.size == 2'b11 ? 1 : 3 + v.wait_n;
`ifdef APB_MASTER_TIMEOUT_EN
        if (v.size != 2'b11 && v.wait_n >= TO) lat = 2 + TO;
`endif
        req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata; req_write = v.write;
        req_size = v.size; req_unsigned = v.uns; wait_n = v.wait_n; err_en = v.err_inj;
        sb.push_back('{v.exp_rdata, v.addr, v.exp_pdata, v.exp_err, v.write, v.exp_pstb, lat, cyc});
        @(posedge pclk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge pclk);
            n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d responses missing", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge pclk) begin
        if (presetn) begin
            if (penable) chk("penable_needs_psel", {31'd0, psel}, 32'd1);
            if (psel && penable && sb.size() > 0) begin
                chk("paddr", paddr, sb[0].paddr);
                chk("pdata", pdata, sb[0].pdata);
                chk("pstb", {28'd0, pstb}, {28'd0, sb[0].pstb});
                chk("pwrite", {31'd0, pwrite}, {31'd0, sb[0].pwrite});
            end
            if (resp_valid) begin
                chk("psel_gap", {31'd0, psel}, 32'd0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
                    chk("latency", 32'(cyc - mon_e.cyc), 32'(mon_e.lat));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         addr          wdata         wr    sz     u     err   w  rdata         e     pstb     pdata
        vt[0]  = '{32'h10, 32'h0,        1'b0, 2'd2, 1'b0, 1'b0, 1, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0};
        vt[1]  = '{32'h10, 32'h000080FF, 1'b1, 2'd2, 1'b0, 1'b0, 1, 32'h0,        1'b0, 4'b1111, 32'h000080FF};
        vt[2]  = '{32'h11, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 1, 32'hFFFFFF80, 1'b0, 4'b0000, 32'h0};
        vt[3]  = '{32'h11, 32'h0,        1'b0, 2'd0, 1'b1, 1'b0, 0, 32'h00000080, 1'b0, 4'b0000, 32'h0};
        vt[4]  = '{32'h10, 32'h0,        1'b0, 2'd1, 1'b0, 1'b0, 2, 32'hFFFF80FF, 1'b0, 4'b0000, 32'h0};
        vt[5]  = '{32'h16, 32'h0,        1'b0, 2'd1, 1'b0, 1'b0, 1, 32'hFFFF8001, 1'b0, 4'b0000, 32'h0};
        vt[6]  = '{32'h15, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 1, 32'h0000007F, 1'b0, 4'b0000, 32'h0};
        vt[7]  = '{32'h22, 32'h00001234, 1'b1, 2'd1, 1'b0, 1'b0, 1, 32'h0,        1'b0, 4'b1100, 32'h12340000};
        vt[8]  = '{32'h20, 32'h0,        1'b0, 2'd2, 1'b0, 1'b0, 1, 32'h1234CCDD, 1'b0, 4'b0000, 32'h0};
        vt[9]  = '{32'h21, 32'h11223344, 1'b1, 2'd2, 1'b0, 1'b1, 1, 32'h0,        1'b1, 4'b1110, 32'h22334400};
        vt[10] = '{32'h20, 32'h0,        1'b0, 2'd2, 1'b0, 1'b0, 1, 32'h1234CCDD, 1'b0, 4'b0000, 32'h0};
        vt[11] = '{32'h23, 32'hFFFFFFA5, 1'b1, 2'd0, 1'b0, 1'b0, 1, 32'h0,        1'b0, 4'b1000, 32'hA5000000};
        vt[12] = '{32'h23, 32'h0000BEEF, 1'b1, 2'd1, 1'b0, 1'b0, 1, 32'h0,        1'b0, 4'b1000, 32'hEF000000};
        vt[13] = '{32'h20, 32'h0,        1'b0, 2'd2, 1'b1, 1'b0, 3, 32'hEF34CCDD, 1'b0, 4'b0000, 32'h0};
        vt[14] = '{32'h10, 32'h0,        1'b0, 2'd2, 1'b0, 1'b1, 1, 32'h0,        1'b1, 4'b0000, 32'h0};
        vt[15] = '{32'h10, 32'h0,        1'b0, 2'd3, 1'b0, 1'b0, 1, 32'h0,        1'b1, 4'b0000, 32'h0};
        vt[16] = '{32'h20, 32'h55555555, 1'b1, 2'd3, 1'b0, 1'b0, 1, 32'h0,        1'b1, 4'b0000, 32'h0};
        vt[17] = '{32'h20, 32'h0,        1'b0, 2'd1, 1'b1, 1'b0, 1, 32'h0000CCDD, 1'b0, 4'b0000, 32'h0};
        vt[18] = '{32'h23, 32'h0,        1'b0, 2'd0, 1'b1, 1'b0, 1, 32'h000000EF, 1'b0, 4'b0000, 32'h0};

        repeat (3) @(negedge pclk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pstb", {28'd0, pstb}, 32'd0);
        preload = 1'b0;
        presetn = 1'b1;
        @(negedge pclk);
        chk("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 19; i++) issue(vt[i]);
        drain();

        // Illegal size never touches the bus
        issue(vt[15]);
        repeat (3) begin
            @(negedge pclk);
            chk("illegal_no_psel", {31'd0, psel}, 32'd0);
        end
        drain();

`ifdef APB_MASTER_TIMEOUT_EN
        issue('{32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 200, 32'h0, 1'b1, 4'b0000, 32'h0});
        drain();
`endif

        // Reset in ACCESS abandons the transaction without a response
        issue('{32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 40, 32'h0, 1'b0, 4'b0000, 32'h0});
        begin
            int n = 0;
            while (!penable && n < 10) begin
                @(negedge pclk);
                n++;
            end
        end
        chk("reached_access", {31'd0, penable}, 32'd1);
        presetn = 1'b0;
        sb.delete();
        @(posedge pclk);
        #1;
        chk("rst_mid_psel", {31'd0, psel}, 32'd0);
        chk("rst_mid_penable", {31'd0, penable}, 32'd0);
        chk("rst_mid_paddr", paddr, 32'd0);
        chk("rst_mid_pdata", pdata, 32'd0);
        chk("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge pclk);
        presetn = 1'b1;
        repeat (10) @(negedge pclk);
        issue('{32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 1, 32'h000080FF, 1'b0, 4'b0000, 32'h0});
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
